// File: rtl/decoder_fifo_pkg.sv
// ============================================================================
// Module      : decoder_fifo_pkg
// Description : Shared defaults and entry layout for the LPC decoder output
//               buffer (decoder_fifo) and its FIFO core (sync_fifo_fwft).
// Macros      : DECODER_FIFO_USER_EN adds a start-of-frame bit to each entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_fifo_pkg;

    localparam int DFLT_DEPTH      = 128;
    localparam int DFLT_DATA_WIDTH = 16;
    localparam int DFLT_LAST_WIDTH = 1;
    localparam int DFLT_LANES      = 5;

    localparam int LANE_CNT_W = $clog2(DFLT_LANES);
    localparam int PTR_W      = $clog2(DFLT_DEPTH) + 1;

    // One stored sample. The user bit exists only when the start-of-frame
    // marker is carried through the FIFO.
    typedef struct packed {
`ifdef DECODER_FIFO_USER_EN
        logic                       user;
`endif
        logic [DFLT_LAST_WIDTH-1:0] last;
        logic [DFLT_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Generic synchronous first-word-fall-through FIFO core.
//               dout always shows the entry at the read pointer.
// Ports       : ACLK, ARESET_N (async, active low)
//               push/din  - write one entry (ignored while full)
//               pop       - remove head entry (ignored while empty)
//               dout      - head entry (raw storage, undefined while empty)
//               full/empty- occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_fwft
    import decoder_fifo_pkg::*;
#(
    parameter int WIDTH = $bits(entry_t),
    parameter int DEPTH = DFLT_DEPTH
) (
    input  logic             ACLK,
    input  logic             ARESET_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide; wrap-around is plain binary overflow.
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage is not reset: the pointers alone define which entries are valid.
    always_ff @(posedge ACLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= din;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
            end
        end
    end

    assign dout = r_mem[r_rd_ptr[c_aw-1:0]];

endmodule

`default_nettype wire

// File: rtl/decoder_fifo.sv
// ============================================================================
// Module      : decoder_fifo
// Description : Stream-to-word buffer at the LPC decoder output. Accepts
//               AXI4-Stream beats of LANES packed samples, serialises them one
//               sample per cycle into a FWFT FIFO, and tags the final sample of
//               each beat with TLAST.
// Ports       : ACLK, ARESET_N          - clock, async active-low reset
//               TDATA/TVALID/TREADY     - input beat handshake
//               TLAST, TUSER            - end / start of frame markers
//               RD_EN                   - pop request
//               DATA_OUT/LAST_OUT/EMPTY - head entry (zero while empty)
//               USER_OUT                - head start-of-frame bit (macro only)
// Macros      : DECODER_FIFO_USER_EN - store TUSER with lane 0, add USER_OUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_fifo
    import decoder_fifo_pkg::*;
#(
    parameter int DEPTH      = DFLT_DEPTH,
    parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
    parameter int LAST_WIDTH = DFLT_LAST_WIDTH,
    parameter int LANES      = DFLT_LANES
) (
    input  logic                        ACLK,
    input  logic                        ARESET_N,
    input  logic [LANES*DATA_WIDTH-1:0] TDATA,
    input  logic                        TVALID,
    output logic                        TREADY,
    input  logic                        TUSER,
    input  logic                        TLAST,
    input  logic                        RD_EN,
    output logic [DATA_WIDTH-1:0]       DATA_OUT,
    output logic [LAST_WIDTH-1:0]       LAST_OUT,
`ifdef DECODER_FIFO_USER_EN
    output logic                        USER_OUT,
`endif
    output logic                        EMPTY
);

    localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef DECODER_FIFO_USER_EN
    localparam int c_entry_w = 1 + LAST_WIDTH + DATA_WIDTH;
`else
    localparam int c_entry_w = LAST_WIDTH + DATA_WIDTH;
`endif

    // Hold register and serialiser state
    logic [LANES*DATA_WIDTH-1:0] r_hold_data;
    logic                        r_hold_last;
    logic                        r_hold_valid;
    logic [c_lane_w-1:0]         r_lane;
    // Keeps TREADY low until the first edge after reset release
    logic                        r_ready_en;

    logic [DATA_WIDTH-1:0] w_lane_data [LANES];
    logic [DATA_WIDTH-1:0] w_cur_data;
    logic [LAST_WIDTH-1:0] w_cur_last;
    logic                  w_is_last_lane;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;
    logic [c_entry_w-1:0]  w_din;
    logic [c_entry_w-1:0]  w_dout;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lane_data[g] = r_hold_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_cur_data     = w_lane_data[r_lane];
    assign w_is_last_lane = (r_lane == c_lane_w'(LANES - 1));
    assign w_cur_last     = w_is_last_lane ? LAST_WIDTH'(r_hold_last) : '0;
    assign w_push         = r_hold_valid && !w_full;
    assign w_pop          = RD_EN && !w_empty;

    // A new beat may land in the same cycle the final lane leaves, so the
    // hold register never idles between back-to-back beats.
    assign TREADY   = r_ready_en && (!r_hold_valid || (w_is_last_lane && w_push));
    assign w_accept = TVALID && TREADY;

`ifdef DECODER_FIFO_USER_EN
    logic r_hold_user;
    logic w_cur_user;

    assign w_cur_user = (r_lane == '0) ? r_hold_user : 1'b0;
    assign w_din      = {w_cur_user, w_cur_last, w_cur_data};

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_hold_user <= 1'b0;
        end else if (w_accept) begin
            r_hold_user <= TUSER;
        end
    end
`else
    logic w_unused_user;

    assign w_unused_user = TUSER;
    assign w_din         = {w_cur_last, w_cur_data};
`endif

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_ready_en   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_lane       <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_hold_data  <= TDATA;
                r_hold_last  <= TLAST;
                r_hold_valid <= 1'b1;
                r_lane       <= '0;
            end else if (w_push) begin
                if (w_is_last_lane) begin
                    r_hold_valid <= 1'b0;
                end else begin
                    r_lane <= r_lane + c_lane_w'(1);
                end
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ACLK     (ACLK),
        .ARESET_N (ARESET_N),
        .push     (w_push),
        .pop      (w_pop),
        .din      (w_din),
        .dout     (w_dout),
        .full     (w_full),
        .empty    (w_empty)
    );

    // Outputs read zero whenever nothing is stored, so reset and underflow
    // never expose stale storage contents.
    assign EMPTY    = w_empty;
    assign DATA_OUT = w_empty ? '0 : w_dout[DATA_WIDTH-1:0];
    assign LAST_OUT = w_empty ? '0 : w_dout[DATA_WIDTH +: LAST_WIDTH];
`ifdef DECODER_FIFO_USER_EN
    assign USER_OUT = w_empty ? 1'b0 : w_dout[c_entry_w-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_fifo.sv
// ============================================================================
// Module      : tb_decoder_fifo
// Description : Self-checking bench for decoder_fifo. A negedge monitor keeps
//               a queue of expected samples built from every accepted beat and
//               compares each popped head entry against it; directed tables and
//               sequences cover reset, single beats, streaming, full, wrap and
//               mid-beat reset.
// Macros      : DECODER_FIFO_USER_EN - also checks USER_OUT.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_decoder_fifo;
    import decoder_fifo_pkg::*;

    localparam int LANES = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 128;

    logic                ACLK = 1'b0;
    logic                ARESET_N;
    logic [LANES*DW-1:0] TDATA;
    logic                TVALID;
    logic                TREADY;
    logic                TUSER;
    logic                TLAST;
    logic                RD_EN;
    logic [DW-1:0]       DATA_OUT;
    logic [0:0]          LAST_OUT;
    logic                EMPTY;
`ifdef DECODER_FIFO_USER_EN
    logic                USER_OUT;
`endif

    decoder_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .LAST_WIDTH (1),
        .LANES      (LANES)
    ) dut (
        .ACLK     (ACLK),
        .ARESET_N (ARESET_N),
        .TDATA    (TDATA),
        .TVALID   (TVALID),
        .TREADY   (TREADY),
        .TUSER    (TUSER),
        .TLAST    (TLAST),
        .RD_EN    (RD_EN),
        .DATA_OUT (DATA_OUT),
        .LAST_OUT (LAST_OUT),
`ifdef DECODER_FIFO_USER_EN
        .USER_OUT (USER_OUT),
`endif
        .EMPTY    (EMPTY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of samples not yet popped
    entry_t model_q[$];
    int     pop_count  = 0;
    int     last_count = 0;
    int     last_at    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: values at the negedge are those seen by the next rising edge.
    always @(negedge ACLK) begin
        entry_t e;
        if (ARESET_N === 1'b1) begin
            if (RD_EN && !EMPTY) begin
                if (model_q.size() == 0) begin
                    chk("pop_without_expected_word", 1, 0);
                end else begin
                    e = model_q.pop_front();
                    chk("pop_data", longint'(DATA_OUT), longint'(e.data));
                    chk("pop_last", longint'(LAST_OUT), longint'(e.last));
`ifdef DECODER_FIFO_USER_EN
                    chk("pop_user", longint'(USER_OUT), longint'(e.user));
`endif
                    pop_count++;
                    if (LAST_OUT != 0) begin
                        last_count++;
                        last_at = pop_count;
                    end
                end
            end
            if (TVALID && TREADY) begin
                for (int k = 0; k < LANES; k++) begin
                    e      = '0;
                    e.data = TDATA[k*DW +: DW];
                    e.last = (k == LANES-1) ? TLAST : 1'b0;
`ifdef DECODER_FIFO_USER_EN
                    e.user = (k == 0) ? TUSER : 1'b0;
`endif
                    model_q.push_back(e);
                end
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic send_beat(input logic [LANES*DW-1:0] d, input logic l,
                             input logic u, input int tmo, output bit ok);
        TDATA  = d;
        TLAST  = l;
        TUSER  = u;
        TVALID = 1'b1;
        ok     = 1'b0;
        for (int i = 0; i < tmo; i++) begin
            @(negedge ACLK);
            if (TREADY) ok = 1'b1;
            @(posedge ACLK); #1;
            if (ok) break;
        end
        TVALID = 1'b0;
    endtask

    task automatic get_word(output logic [DW-1:0] d, output logic l,
                            output logic u, output bit ok);
        RD_EN = 1'b1;
        ok    = 1'b0;
        d     = '0;
        l     = 1'b0;
        u     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (!EMPTY) begin
                d  = DATA_OUT;
                l  = LAST_OUT[0];
`ifdef DECODER_FIFO_USER_EN
                u  = USER_OUT;
`endif
                ok = 1'b1;
            end
            @(posedge ACLK); #1;
            if (ok) break;
        end
        RD_EN = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    function automatic logic [LANES*DW-1:0] rand_beat();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[LANES*DW-1:0];
    endfunction

    typedef struct {
        logic [LANES*DW-1:0] tdata;
        logic                tlast;
        logic                tuser;
        logic [DW-1:0]       w[LANES];
    } vec_t;

    vec_t vt[4];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        int            beats;
        int            seen;
        int            base;
        int            stale;
        int            occ;
        logic [DW-1:0] d;
        logic          l;
        logic          u;

        vt[0] = '{80'h0005_0004_0003_0002_0001, 1'b1, 1'b1,
                  '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005}};
        vt[1] = '{80'hFFFF_0000_AAAA_5555_1234, 1'b0, 1'b0,
                  '{16'h1234, 16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF}};
        vt[2] = '{80'h8000_4000_2000_1000_0800, 1'b1, 1'b1,
                  '{16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000}};
        vt[3] = '{80'hDEAD_BEEF_CAFE_F00D_0001, 1'b0, 1'b0,
                  '{16'h0001, 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD}};

        // ---------------- reset ----------------
        ARESET_N = 1'b0;
        TDATA    = '0;
        TVALID   = 1'b0;
        TLAST    = 1'b0;
        TUSER    = 1'b0;
        RD_EN    = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("reset_empty", EMPTY, 1);
        chk("reset_tready", TREADY, 0);
        chk("reset_data_out", DATA_OUT, 0);
        chk("reset_last_out", LAST_OUT, 0);
        ARESET_N = 1'b1;
        #1;
        chk("tready_before_first_edge", TREADY, 0);
        @(negedge ACLK);
        chk("tready_after_first_edge", TREADY, 1);
        @(posedge ACLK); #1;

        // RD_EN on an empty FIFO must not move the read pointer
        RD_EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("empty_rd_en_ignored", EMPTY, 1);
        end
        @(posedge ACLK); #1;
        RD_EN = 1'b0;

        // ---------------- single-beat table ----------------
        for (int v = 0; v < 4; v++) begin
            send_beat(vt[v].tdata, vt[v].tlast, vt[v].tuser, 20, ok);
            chk("tbl_accept", ok, 1);
            for (int w = 0; w < LANES; w++) begin
                get_word(d, l, u, ok);
                chk("tbl_word_present", ok, 1);
                chk("tbl_data", d, vt[v].w[w]);
                chk("tbl_last", l, (w == LANES-1) ? vt[v].tlast : 1'b0);
`ifdef DECODER_FIFO_USER_EN
                chk("tbl_user", u, (w == 0) ? vt[v].tuser : 1'b0);
`endif
            end
            @(negedge ACLK);
            chk("tbl_empty_after", EMPTY, 1);
            @(posedge ACLK); #1;
        end

        // ---------------- continuous stream, 1920 beats ----------------
        pop_count  = 0;
        last_count = 0;
        last_at    = 0;
        RD_EN      = 1'b1;
        for (int b = 1; b <= 1920; b++) begin
            send_beat(rand_beat(), (b == 1920), 1'($urandom_range(0, 1)), 20, ok);
            if (!ok) begin
                chk("stream_accept_timeout", b, 0);
                break;
            end
        end
        cycles(20);
        chk("stream_word_count", pop_count, 9600);
        chk("stream_last_count", last_count, 1);
        chk("stream_last_position", last_at, 9600);
        chk("stream_model_drained", model_q.size(), 0);
        chk("stream_empty", EMPTY, 1);
        RD_EN = 1'b0;

        // ---------------- fill until full ----------------
        beats = 0;
        for (int b = 0; b < 40; b++) begin
            send_beat(rand_beat(), 1'b0, 1'b0, 20, ok);
            if (!ok) break;
            beats++;
        end
        chk("full_beats_accepted", beats, 26);
        @(negedge ACLK);
        chk("full_tready_low", TREADY, 0);
        chk("full_not_empty", EMPTY, 0);
        @(posedge ACLK); #1;
        // 128 stored + lanes 3,4 held: the second single pop lets lane 4 go
        seen = -1;
        for (int k = 1; k <= 4 && seen < 0; k++) begin
            RD_EN = 1'b1;
            @(posedge ACLK); #1;
            RD_EN = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge ACLK);
                if (TREADY && seen < 0) seen = k;
            end
            @(posedge ACLK); #1;
        end
        chk("full_pops_until_tready", seen, 2);
        base  = pop_count;
        RD_EN = 1'b1;
        cycles(160);
        RD_EN = 1'b0;
        chk("full_total_words", pop_count - base + seen, 130);
        chk("full_model_drained", model_q.size(), 0);
        chk("full_empty_after", EMPTY, 1);

        // ---------------- steady push+pop at 64 entries, wrap ----------------
        for (int b = 0; b < 13; b++) begin
            send_beat(rand_beat(), 1'b0, 1'b0, 20, ok);
        end
        cycles(10);
        RD_EN = 1'b1;
        for (int b = 0; b < 40; b++) begin
            send_beat(rand_beat(), (b == 39), 1'b0, 20, ok);
            if (!ok) begin
                chk("wrap_accept_timeout", b, 0);
                break;
            end
        end
        RD_EN = 1'b0;
        cycles(10);
        // 64 held steady during streaming, plus the five lanes of the final beat
        occ  = model_q.size();
        base = pop_count;
        RD_EN = 1'b1;
        cycles(100);
        RD_EN = 1'b0;
        chk("wrap_occupancy", pop_count - base, 69);
        chk("wrap_model_occupancy", occ, 69);
        chk("wrap_empty_after", EMPTY, 1);

        // ---------------- reset mid-beat ----------------
        send_beat(80'h0050_0040_0030_0020_0010, 1'b1, 1'b1, 20, ok);
        repeat (3) @(posedge ACLK);
        #1;
        chk("midreset_lanes_present", EMPTY, 0);
        #1;
        ARESET_N = 1'b0;
        model_q.delete();
        #1;
        chk("midreset_empty_async", EMPTY, 1);
        chk("midreset_tready_low", TREADY, 0);
        chk("midreset_data_zero", DATA_OUT, 0);
        repeat (2) @(negedge ACLK);
        ARESET_N = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            if (!EMPTY) stale++;
        end
        chk("midreset_no_stale", stale, 0);
        chk("midreset_hold_cleared", TREADY, 1);
        @(posedge ACLK); #1;
        send_beat(vt[0].tdata, vt[0].tlast, vt[0].tuser, 20, ok);
        chk("post_reset_accept", ok, 1);
        for (int w = 0; w < LANES; w++) begin
            get_word(d, l, u, ok);
            chk("post_reset_data", d, vt[0].w[w]);
        end
        @(negedge ACLK);
        chk("post_reset_empty", EMPTY, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_fifo.md
Name: decoder_fifo

Overview:
- Stream-to-word buffer at the LPC decoder output.
- Accepts AXI4-Stream beats of LANES packed DATA_WIDTH-bit samples and serialises them one sample per cycle into a synchronous FIFO.
- Presents the samples in first-word-fall-through form to a downstream reader.
- Carries frame boundaries: TLAST is attached to the final sample of the beat.

Parameters:
- DEPTH, 128, FIFO entries; power of two, >= 2*LANES.
- DATA_WIDTH, 16, sample width in bits.
- LAST_WIDTH, 1, width of the stored last-flag field.
- LANES, 5, samples per input beat; TDATA width = LANES*DATA_WIDTH = 80.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET_N  in  1  asynchronous active-low reset.
- TDATA  in  LANES*DATA_WIDTH  packed samples; lane k = TDATA[k*DATA_WIDTH +: DATA_WIDTH].
- TVALID  in  1  beat valid.
- TREADY  out  1  beat accepted when TVALID && TREADY.
- TUSER  in  1  start-of-frame marker (see Optional Feature).
- TLAST  in  1  last beat of frame.
- RD_EN  in  1  pop request.
- DATA_OUT  out  DATA_WIDTH  head sample, valid while EMPTY=0.
- LAST_OUT  out  LAST_WIDTH  last-flag field of the head entry.
- EMPTY  out  1  FIFO holds no entries.

Behaviour:
- Reset (ARESET_N=0, asynchronous):
  - Clears the hold register, lane counter, pointers and count.
  - EMPTY=1, DATA_OUT=0, LAST_OUT=0, TREADY=0.
  - TREADY rises on the first clock edge after reset deassertion.
  - Reset mid-operation discards all stored and held data.
- Hold register:
  - Captures TDATA, TLAST and TUSER on an accepted beat.
  - Sets hold_valid and lane=0.
- Serialiser:
  - Each cycle with hold_valid=1 and FIFO not full, pushes lane[lane] and increments lane.
  - On the lane=LANES-1 push, clears hold_valid.
  - Lane order is lane 0 (TDATA[15:0]) first and lane LANES-1 (TDATA[79:64]) last.
- Last flag:
  - The last-flag field is TLAST zero-extended to LAST_WIDTH on lane LANES-1.
  - It is 0 on all other lanes.
- TREADY:
  - TREADY = !hold_valid || (lane==LANES-1 && push).
  - This allows back-to-back beats with no bubble at the hold register.
  - Sustained throughput is one beat per LANES cycles.
  - TREADY does not depend on TVALID.
- FIFO core:
  - DEPTH entries of {last, data}.
  - Read/write pointers of log2(DEPTH)+1 bits.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - Pointer wrap-around is natural binary overflow.
- Read side, first-word-fall-through:
  - DATA_OUT/LAST_OUT always show the entry at the read pointer.
  - A pop occurs when RD_EN && !EMPTY.
  - RD_EN while EMPTY is ignored; no underflow, outputs hold.
  - A write into an empty FIFO makes EMPTY=0 one cycle after the push edge, with the pushed data on DATA_OUT.
- Full:
  - The serialiser stalls at its current lane and no entry is overwritten.
  - TREADY stays 0 while hold_valid=1.
- Simultaneous push and pop: both occur; occupancy is unchanged. Push while full is not allowed even if a pop occurs in the same cycle.
- TVALID deassertion mid-frame: no effect on samples already held.

Optional Feature:
- Macro: DECODER_FIFO_USER_EN.
- When defined:
  - Adds output USER_OUT (1 bit).
  - TUSER is stored with lane 0 of its beat and with 0 on the other lanes.
  - USER_OUT is the head entry's bit and follows FWFT timing like LAST_OUT.
- When undefined: TUSER is ignored and no user bit is stored.

Decomposition:
- Package decoder_fifo_pkg:
  - DATA_WIDTH/LANES/DEPTH defaults.
  - LANE_CNT_W = $clog2(LANES).
  - PTR_W = $clog2(DEPTH)+1.
  - Entry typedef {last, data}.
- Sub-module sync_fifo_fwft, generic FIFO core:
  - Ports: push, pop, din, dout, full, empty.
  - Contains the storage array and pointer logic.
- decoder_fifo top level: instantiates sync_fifo_fwft and holds the hold register and serialiser.

Test Plan:
- Reset release → EMPTY=1, TREADY=0 during reset, TREADY=1 after the first edge; RD_EN=1 on empty FIFO → no pointer change.
- One beat TDATA=0x0005_0004_0003_0002_0001, TLAST=1, RD_EN=1 → DATA_OUT sequence 1,2,3,4,5; LAST_OUT=1 only with 5; EMPTY returns to 1.
- Continuous TVALID, 1920 beats with TLAST on beat 1920, RD_EN=1 → 9600 words in order; exactly one LAST_OUT=1, on word 9600.
- RD_EN=0, stream until full → exactly 128 entries stored, then TREADY=0 holds; RD_EN=1 → no loss or duplication, data in order.
- Simultaneous push and pop at count=64 → count stays 64; pointer wrap past entry 127 preserves order.
- Assert ARESET_N=0 mid-beat with 3 lanes pushed → EMPTY=1 immediately (asynchronous), hold register cleared, no stale data afterward.
